// File: rtl/scanconv_pkg.sv
// scanconv_pkg: shared definitions for the 15 kHz -> 31 kHz line-doubling scan converter.
//   - RGB field positions/widths of the 8-bit BBGGGRRR pixel
//   - default geometry constants (line-buffer depth, output hsync width, default line length)
//   - line_word_t: the 9-bit word held in the line buffer {blank, rgb}
//   - halve_rgb(): per-channel right shift used for the dimmed second pass
package scanconv_pkg;

   localparam int unsigned R_LSB = 0;
   localparam int unsigned R_W   = 3;
   localparam int unsigned G_LSB = 3;
   localparam int unsigned G_W   = 3;
   localparam int unsigned B_LSB = 6;
   localparam int unsigned B_W   = 2;

   localparam int unsigned DEPTH_DEF     = 512;
   localparam int unsigned HS_WIDTH_DEF  = 48;
   localparam int unsigned L_DEFAULT_DEF = 384;

   typedef struct packed {
      logic       blank;
      logic [7:0] rgb;
   } line_word_t;

   // Each channel is shifted inside its own field so no bits leak between colours.
   function automatic logic [7:0] halve_rgb(input logic [7:0] c);
      logic [7:0] h;
      h = '0;
      h[R_LSB +: R_W] = c[R_LSB +: R_W] >> 1;
      h[G_LSB +: G_W] = c[G_LSB +: G_W] >> 1;
      h[B_LSB +: B_W] = c[B_LSB +: B_W] >> 1;
      return h;
   endfunction

endpackage

// File: rtl/scanconv_linebuf.sv
// scanconv_linebuf: ping-pong line buffer, two banks of DEPTH line words.
// The bank select is the MSB of each address.
// Ports:
//   clk25m  clock
//   we      write enable
//   waddr   {bank, pixel} write address
//   wdata   line word to store
//   raddr   {bank, pixel} read address
//   rdata   registered read data (one-cycle latency)
module scanconv_linebuf
   import scanconv_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic        clk25m,
   input  logic        we,
   input  logic [AW:0] waddr,
   input  line_word_t  wdata,
   input  logic [AW:0] raddr,
   output line_word_t  rdata
);

   line_word_t mem [2*DEPTH];

   always_ff @(posedge clk25m) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/scanconvert2x.sv
// scanconvert2x: line-doubling scan converter, 15 kHz arcade raster in, 31 kHz raster out.
// Each source line is captured (at ce_in) into one line-buffer bank while the previously
// completed line is replayed twice (at ce_out) from the other bank.
// Build option: define SCANLINES_EN to halve every colour channel of non-blank pixels on the
// second replay of each line; without it both replays are identical.
// Ports:
//   clk25m                     sole clock
//   reset                      synchronous, active-high
//   ce_in / ce_out             source (1x) and output (2x) pixel strobes
//   hsync_i vsync_i blank_i    source timing, active-high
//   rgb_i                      source pixel, BBGGGRRR
//   hsync_o vsync_o blank_o    output timing, active-high
//   rgb_o                      output pixel, BBGGGRRR
module scanconvert2x
   import scanconv_pkg::*;
#(
   parameter int unsigned DEPTH     = DEPTH_DEF,
   parameter int unsigned HS_WIDTH  = HS_WIDTH_DEF,
   parameter int unsigned L_DEFAULT = L_DEFAULT_DEF
) (
   input  logic       clk25m,
   input  logic       reset,
   input  logic       ce_in,
   input  logic       ce_out,
   input  logic       hsync_i,
   input  logic       vsync_i,
   input  logic       blank_i,
   input  logic [7:0] rgb_i,
   output logic       hsync_o,
   output logic       vsync_o,
   output logic       blank_o,
   output logic [7:0] rgb_o
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam logic [AW-1:0] WxMax = AW'(DEPTH - 1);
   localparam logic [AW:0]   LDef  = (AW+1)'(L_DEFAULT);
   localparam logic [AW:0]   HsW   = (AW+1)'(HS_WIDTH);

   // Write side
   logic [AW-1:0] wx_q;
   logic          wbank_q;
   logic [AW:0]   len_q;
   logic          hs_prev_q;
   logic          restart_q;
   logic          hs_rise;
   line_word_t    wr_word;

   // Read side and output pipeline
   logic [AW-1:0] rx_q;
   logic          rbank_q;
   logic          pass_q;
   logic          hs_s1_q;
   logic          oob_s1_q;
   line_word_t    rd_word;
   logic [7:0]    rgb_d;

   assign hs_rise = ce_in & hsync_i & ~hs_prev_q;
   assign wr_word = '{blank: blank_i, rgb: (blank_i ? 8'h00 : rgb_i)};

   always_ff @(posedge clk25m) begin
      if (reset) begin
         wx_q      <= '0;
         wbank_q   <= 1'b0;
         len_q     <= LDef;
         hs_prev_q <= 1'b0;
         restart_q <= 1'b0;
      end else begin
         restart_q <= hs_rise;
         if (ce_in) begin
            hs_prev_q <= hsync_i;
            if (hs_rise) begin
               // wx saturates at DEPTH-1, so wx+1 never exceeds DEPTH.
               len_q   <= {1'b0, wx_q} + (AW+1)'(1);
               wx_q    <= '0;
               wbank_q <= ~wbank_q;
            end else if (wx_q != WxMax) begin
               wx_q <= wx_q + AW'(1);
            end
         end
      end
   end

   // Restart outranks ce_out; wbank has already flipped, so the finished bank is ~wbank.
   always_ff @(posedge clk25m) begin
      if (reset) begin
         rx_q    <= '0;
         rbank_q <= 1'b1;
         pass_q  <= 1'b0;
         vsync_o <= 1'b0;
      end else if (restart_q) begin
         rx_q    <= '0;
         rbank_q <= ~wbank_q;
         pass_q  <= 1'b0;
         vsync_o <= vsync_i;
      end else if (ce_out) begin
         if ({1'b0, rx_q} == len_q - (AW+1)'(1)) begin
            rx_q    <= '0;
            pass_q  <= ~pass_q;
            vsync_o <= vsync_i;
         end else begin
            rx_q <= rx_q + AW'(1);
         end
      end
   end

   scanconv_linebuf #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_linebuf (
      .clk25m (clk25m),
      .we     (ce_in),
      .waddr  ({wbank_q, wx_q}),
      .wdata  (wr_word),
      .raddr  ({rbank_q, rx_q}),
      .rdata  (rd_word)
   );

   // Stage 1 runs alongside the RAM read so timing flags line up with the returned word.
   always_ff @(posedge clk25m) begin
      if (reset) begin
         hs_s1_q  <= 1'b0;
         oob_s1_q <= 1'b0;
         hsync_o  <= 1'b0;
         blank_o  <= 1'b0;
         rgb_o    <= '0;
      end else begin
         hs_s1_q  <= ({1'b0, rx_q} < HsW);
         oob_s1_q <= ({1'b0, rx_q} >= len_q);
         hsync_o  <= hs_s1_q;
         blank_o  <= oob_s1_q | rd_word.blank;
         rgb_o    <= rgb_d;
      end
   end

`ifdef SCANLINES_EN
   logic pass_s1_q;

   always_ff @(posedge clk25m) begin
      if (reset) begin
         pass_s1_q <= 1'b0;
      end else begin
         pass_s1_q <= pass_q;
      end
   end
`else
   logic unused_pass;
   assign unused_pass = pass_q;
`endif

   always_comb begin
      rgb_d = rd_word.rgb;
      if (oob_s1_q) begin
         rgb_d = '0;
      end
`ifdef SCANLINES_EN
      else if (pass_s1_q && !rd_word.blank) begin
         rgb_d = halve_rgb(rd_word.rgb);
      end
`endif
   end

endmodule

// File: tb/tb_scanconvert2x.sv
// tb_scanconvert2x: scoreboard bench for scanconvert2x.
// Clocking: ce_in every 4 clk25m cycles, ce_out every 2 (coinciding with ce_in on phase 0).
// The driver keeps a behavioural reference of the converter; on each output-position change it
// pushes the expected pixel, due 2 cycles later, and the monitor pops and compares.
module tb_scanconvert2x;

   logic       clk25m = 1'b0;
   logic       reset;
   logic       ce_in;
   logic       ce_out;
   logic       hsync_i;
   logic       vsync_i;
   logic       blank_i;
   logic [7:0] rgb_i;
   logic       hsync_o;
   logic       vsync_o;
   logic       blank_o;
   logic [7:0] rgb_o;

   always #5 clk25m = ~clk25m;

   scanconvert2x dut (
      .clk25m  (clk25m),
      .reset   (reset),
      .ce_in   (ce_in),
      .ce_out  (ce_out),
      .hsync_i (hsync_i),
      .vsync_i (vsync_i),
      .blank_i (blank_i),
      .rgb_i   (rgb_i),
      .hsync_o (hsync_o),
      .vsync_o (vsync_o),
      .blank_o (blank_o),
      .rgb_o   (rgb_o)
   );

   typedef struct {
      int         due;
      bit         hs;
      bit         bl;
      logic [7:0] rgb;
      bit         known;
   } exp_t;

   exp_t sbq[$];
   int   checks  = 0;
   int   errors  = 0;
   int   cyc     = 0;
   bit   run_chk = 0;

   // Reference state
   logic [8:0] mem  [1024];
   bit         mval [1024];
   int         m_wx, m_wbank, m_len, m_rx, m_rbank;
   bit         m_hsp, m_rq, m_pass, m_vs;

   function automatic logic [7:0] half(input logic [7:0] c);
      logic [1:0] b;
      logic [2:0] g;
      logic [2:0] r;
      b = c[7:6];
      g = c[5:3];
      r = c[2:0];
      return {b >> 1, g >> 1, r >> 1};
   endfunction

   task automatic step(input bit r, input bit ci, input bit co, input bit hs, input bit vs,
                       input bit bl, input logic [7:0] px);
      bit   moved;
      int   idx;
      exp_t e;
      reset = r; ce_in = ci; ce_out = co;
      hsync_i = hs; vsync_i = vs; blank_i = bl; rgb_i = px;
      @(posedge clk25m);
      cyc++;
      if (r) begin
         m_wx = 0; m_wbank = 0; m_len = 384; m_hsp = 0; m_rq = 0;
         m_rx = 0; m_rbank = 1; m_pass = 0; m_vs = 0;
      end else begin
         moved = 0;
         if (m_rq) begin
            m_rx = 0; m_rbank = 1 - m_wbank; m_pass = 0; m_vs = vs; moved = 1;
         end else if (co) begin
            moved = 1;
            if (m_rx == m_len - 1) begin
               m_rx = 0; m_pass = ~m_pass; m_vs = vs;
            end else begin
               m_rx++;
            end
         end
         m_rq = ci && hs && !m_hsp;
         if (ci) begin
            mem[m_wbank*512 + m_wx]  = {bl, (bl ? 8'h00 : px)};
            mval[m_wbank*512 + m_wx] = 1;
            if (m_rq) begin
               m_len = (m_wx + 1 > 512) ? 512 : m_wx + 1;
               m_wx = 0;
               m_wbank = 1 - m_wbank;
            end else if (m_wx < 511) begin
               m_wx++;
            end
            m_hsp = hs;
         end
         if (moved) begin
            e.due = cyc + 2;
            e.hs  = (m_rx < 48);
            idx   = m_rbank*512 + m_rx;
            if (m_rx >= m_len) begin
               e.bl = 1; e.rgb = 8'h00; e.known = 1;
            end else begin
               e.known = mval[idx];
               e.bl    = mem[idx][8];
               e.rgb   = mem[idx][7:0];
`ifdef SCANLINES_EN
               if (m_pass && !e.bl) e.rgb = half(e.rgb);
`endif
            end
            sbq.push_back(e);
         end
      end
      #1;
   endtask

   // One source line: hsync high for the first hs_len pixels, blank below blank_to,
   // pixel = low byte of x (or 8'hFF when ff is set).
   task automatic src_line(input int len, input int hs_len, input int blank_to, input bit vs,
                           input bit ff);
      logic [7:0] px;
      for (int x = 0; x < len; x++) begin
         px = ff ? 8'hFF : x[7:0];
         for (int p = 0; p < 4; p++) begin
            step(0, (p == 0), (p % 2 == 0), (x < hs_len), vs, (x < blank_to), px);
         end
      end
   endtask

   task automatic chk_zero(input string name, input logic [7:0] got);
      checks++;
      if (got !== 8'h00) begin
         errors++;
         $display("FAIL %s got=%h want=00", name, got);
      end
   endtask

   always @(negedge clk25m) begin
      exp_t e;
      if (run_chk) begin
         checks++;
         if (vsync_o !== m_vs) begin
            errors++;
            $display("FAIL vsync_o cyc=%0d got=%b want=%b", cyc, vsync_o, m_vs);
         end
         while (sbq.size() > 0 && sbq[0].due < cyc) begin
            e = sbq.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_sample due=%0d now=%0d got=none want=checked", e.due, cyc);
         end
         if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            checks++;
            if (hsync_o !== e.hs) begin
               errors++;
               $display("FAIL hsync_o cyc=%0d got=%b want=%b", cyc, hsync_o, e.hs);
            end
            if (e.known) begin
               checks++;
               if (blank_o !== e.bl) begin
                  errors++;
                  $display("FAIL blank_o cyc=%0d got=%b want=%b", cyc, blank_o, e.bl);
               end
               checks++;
               if (rgb_o !== e.rgb) begin
                  errors++;
                  $display("FAIL rgb_o cyc=%0d got=%h want=%h", cyc, rgb_o, e.rgb);
               end
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 1024; i++) mval[i] = 0;
      repeat (3) step(1, 0, 0, 0, 0, 0, 8'h00);
      chk_zero("reset_hsync_o", {7'd0, hsync_o});
      chk_zero("reset_vsync_o", {7'd0, vsync_o});
      chk_zero("reset_blank_o", {7'd0, blank_o});
      chk_zero("reset_rgb_o", rgb_o);
      run_chk = 1;
      // Free-running at L_DEFAULT before any source hsync.
      src_line(200, 0, 0, 0, 0);
      // Measured 384-pixel lines, pixel = index.
      repeat (3) src_line(384, 32, 0, 0, 0);
      // Leading 64 pixels blanked with white data.
      repeat (2) src_line(384, 32, 64, 0, 1);
      // Three lines of vsync.
      repeat (3) src_line(384, 32, 0, 1, 0);
      repeat (2) src_line(384, 32, 0, 0, 0);
      // White lines: second pass dimmed when scanlines are built in.
      repeat (2) src_line(384, 32, 0, 0, 1);
      // Short line cuts a replay mid-line.
      src_line(100, 32, 0, 0, 0);
      // Over-long line: length saturates at the buffer depth.
      src_line(600, 32, 0, 0, 0);
      repeat (2) src_line(384, 32, 0, 0, 0);
      repeat (4) step(0, 0, 0, 0, 0, 0, 8'h00);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d want=0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
